// File: rtl/pipeline_control.sv
// Four-stage pipeline controller: produces per-stage enables, stage-valid bits,
// a fetch flush on jumps, and a saturating count of stalled cycles.
module pipeline_control (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_done,
  input  logic        mem_done,
  input  logic [4:0]  d_rs1,
  input  logic [4:0]  d_rs2,
  input  logic        d_uses_rs1,
  input  logic        d_uses_rs2,
  input  logic [4:0]  c_rd,
  input  logic        c_writes_rd,
  input  logic        c_is_load,
  input  logic        jump_valid,
  output logic        en_fetch,
  output logic        en_decode,
  output logic        en_compute,
  output logic        en_mem,
  output logic        en_wb,
  output logic        flush,
  output logic        v_d,
  output logic        v_c,
  output logic        v_m,
  output logic        v_w,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;
  typedef enum logic [2:0] {ACT_ADVANCE, ACT_RESET, ACT_REFILL, ACT_WAIT, ACT_JUMP, ACT_BUBBLE} action_t;

  state_t  state;
  action_t action;

  logic mem_busy;
  logic jump;
  logic rs1_match;
  logic rs2_match;
  logic hazard;

  assign mem_busy  = v_m & ~mem_done;
  assign jump      = v_m & jump_valid & ~mem_busy;
  assign rs1_match = d_uses_rs1 & (d_rs1 == c_rd);
  assign rs2_match = d_uses_rs2 & (d_rs2 == c_rd);
  assign hazard    = v_d & v_c & c_is_load & c_writes_rd & (c_rd != 5'd0) & (rs1_match | rs2_match);

  // Once memory completes, a MEM_WAIT cycle is resolved exactly like a RUN cycle,
  // so a load-use pair held during the wait still gets its bubble.
  always_comb begin
    action = ACT_ADVANCE;
    if (reset)
      action = ACT_RESET;
    else if (state == FLUSH)
      action = ACT_REFILL;
    else if (state == MEM_WAIT && !mem_done)
      action = ACT_WAIT;
    else if (jump)
      action = ACT_JUMP;
    else if (mem_busy)
      action = ACT_WAIT;
    else if (hazard)
      action = ACT_BUBBLE;
  end

  always_comb begin
    en_fetch   = 1'b0;
    en_decode  = 1'b0;
    en_compute = 1'b0;
    en_mem     = 1'b0;
    en_wb      = 1'b0;
    flush      = 1'b0;
    case (action)
      ACT_RESET: ;
      ACT_REFILL: en_fetch = 1'b1;
      ACT_WAIT:   en_mem   = 1'b1;
      ACT_JUMP: begin
        flush    = 1'b1;
        en_fetch = 1'b1;
        en_mem   = 1'b1;
        en_wb    = v_w;
      end
      ACT_BUBBLE: begin
        en_compute = 1'b1;
        en_mem     = v_m;
        en_wb      = v_w;
      end
      default: begin
        en_fetch   = 1'b1;
        en_decode  = v_d;
        en_compute = v_c;
        en_mem     = v_m;
        en_wb      = v_w;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    case (action)
      ACT_RESET: begin
        state        <= RUN;
        v_d          <= 1'b0;
        v_c          <= 1'b0;
        v_m          <= 1'b0;
        v_w          <= 1'b0;
        stall_cycles <= 16'd0;
      end
      ACT_REFILL: begin
        state <= RUN;
        v_d   <= fetch_done;
        v_w   <= 1'b0;
      end
      ACT_WAIT: begin
        state        <= MEM_WAIT;
        v_w          <= 1'b0;
        stall_cycles <= (stall_cycles == 16'hFFFF) ? stall_cycles : stall_cycles + 16'd1;
      end
      ACT_JUMP: begin
        state <= FLUSH;
        v_d   <= 1'b0;
        v_c   <= 1'b0;
        v_m   <= 1'b0;
        v_w   <= v_m;
      end
      ACT_BUBBLE: begin
        state        <= RUN;
        v_c          <= 1'b0;
        v_m          <= v_c;
        v_w          <= v_m;
        stall_cycles <= (stall_cycles == 16'hFFFF) ? stall_cycles : stall_cycles + 16'd1;
      end
      default: begin
        state <= RUN;
        v_d   <= fetch_done;
        v_c   <= v_d;
        v_m   <= v_c;
        v_w   <= v_m;
      end
    endcase
  end

endmodule

// File: tb/tb_pipeline_control.sv
// Randomized and directed checks of pipeline_control against a stage-array model
// of the pipeline that is consulted on every cycle.
module tb_pipeline_control;

  logic        clock = 1'b0;
  logic        reset, fetch_done, mem_done, jump_valid;
  logic [4:0]  d_rs1, d_rs2, c_rd;
  logic        d_uses_rs1, d_uses_rs2, c_writes_rd, c_is_load;
  logic        en_fetch, en_decode, en_compute, en_mem, en_wb, flush;
  logic        v_d, v_c, v_m, v_w;
  logic [15:0] stall_cycles;

  int total = 0;
  int bad = 0;

  // Model: valid bit per stage (0=decode .. 3=writeback), pending refill, stall count.
  bit m_valid[4];
  bit m_refill;
  int m_stall;

  pipeline_control dut (
    .clock(clock), .reset(reset), .fetch_done(fetch_done), .mem_done(mem_done),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2),
    .c_rd(c_rd), .c_writes_rd(c_writes_rd), .c_is_load(c_is_load), .jump_valid(jump_valid),
    .en_fetch(en_fetch), .en_decode(en_decode), .en_compute(en_compute), .en_mem(en_mem),
    .en_wb(en_wb), .flush(flush), .v_d(v_d), .v_c(v_c), .v_m(v_m), .v_w(v_w),
    .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit fd, input bit md, input bit jv,
                               input bit [4:0] rs1, input bit [4:0] rs2, input bit u1, input bit u2,
                               input bit [4:0] rd, input bit wr, input bit ld);
    reset = rst; fetch_done = fd; mem_done = md; jump_valid = jv;
    d_rs1 = rs1; d_rs2 = rs2; d_uses_rs1 = u1; d_uses_rs2 = u2;
    c_rd = rd; c_writes_rd = wr; c_is_load = ld;
    #1;
  endtask

  task automatic quiet(input bit rst, input bit fd, input bit md, input bit jv);
    applyStimulus(rst, fd, md, jv, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // One clock: compare every output against the model at the falling edge,
  // then let the model take the same rising edge as the DUT.
  task automatic step();
    bit busy, jmp, haz, exp_flush, n_refill;
    bit [4:0] exp_en;
    bit n_valid[4];
    int n_stall;
    logic [25:0] got, want;
    @(negedge clock);
    busy = m_valid[2] && !mem_done;
    jmp  = m_valid[2] && jump_valid && !busy;
    haz  = m_valid[0] && m_valid[1] && c_is_load && c_writes_rd && (c_rd != 0) &&
           ((d_uses_rs1 && d_rs1 == c_rd) || (d_uses_rs2 && d_rs2 == c_rd));
    n_valid = m_valid;
    n_stall = m_stall;
    n_refill = 1'b0;
    exp_en = 5'b00000;
    exp_flush = 1'b0;
    if (reset) begin
      foreach (n_valid[i]) n_valid[i] = 1'b0;
      n_stall = 0;
    end else if (m_refill) begin
      exp_en = 5'b10000;
      n_valid[0] = fetch_done;
      n_valid[3] = 1'b0;
    end else if (jmp) begin
      exp_flush = 1'b1;
      exp_en = {1'b1, 1'b0, 1'b0, 1'b1, m_valid[3]};
      n_valid[0] = 1'b0; n_valid[1] = 1'b0; n_valid[2] = 1'b0;
      n_valid[3] = m_valid[2];
      n_refill = 1'b1;
    end else if (busy) begin
      exp_en = 5'b00010;
      n_valid[3] = 1'b0;
      n_stall = (m_stall + 1 > 65535) ? 65535 : m_stall + 1;
    end else if (haz) begin
      exp_en = {2'b00, 1'b1, m_valid[2], m_valid[3]};
      n_valid[1] = 1'b0;
      n_valid[2] = m_valid[1];
      n_valid[3] = m_valid[2];
      n_stall = (m_stall + 1 > 65535) ? 65535 : m_stall + 1;
    end else begin
      exp_en = {1'b1, m_valid[0], m_valid[1], m_valid[2], m_valid[3]};
      for (int i = 3; i > 0; i--) n_valid[i] = m_valid[i-1];
      n_valid[0] = fetch_done;
    end
    got  = {en_fetch, en_decode, en_compute, en_mem, en_wb, flush, v_d, v_c, v_m, v_w, stall_cycles};
    want = {exp_en, exp_flush, m_valid[0], m_valid[1], m_valid[2], m_valid[3], m_stall[15:0]};
    checkOutput("cycle", {6'd0, got}, {6'd0, want});
    @(posedge clock);
    #1;
    m_valid = n_valid;
    m_stall = n_stall;
    m_refill = n_refill;
  endtask

  initial begin
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_refill = 1'b0;
    m_stall = 0;
    quiet(1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clock);
    #1;
    step();
    checkOutput("rst_enables", {en_fetch, en_decode, en_compute, en_mem, en_wb, flush}, 6'b000000);
    step();

    // Fill from empty.
    quiet(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("first_cycle_en", {en_fetch, en_decode, en_compute, en_mem, en_wb}, 5'b10000);
    repeat (4) step();
    checkOutput("fill_en", {en_fetch, en_decode, en_compute, en_mem, en_wb}, 5'b11111);
    checkOutput("fill_valid", {v_d, v_c, v_m, v_w}, 4'b1111);
    checkOutput("fill_stall", stall_cycles, 16'd0);

    // Load-use on r5, then the same pattern on r0.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    checkOutput("hazard_en", {en_fetch, en_decode}, 2'b00);
    step();
    checkOutput("bubble_vc", v_c, 1'b0);
    checkOutput("bubble_stall", stall_cycles, 16'd1);
    quiet(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (4) step();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    checkOutput("rd0_en", {en_fetch, en_decode}, 2'b11);
    step();
    checkOutput("rd0_stall", stall_cycles, 16'd1);

    // Three cycles of memory wait, then release.
    quiet(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("wait_en", {en_fetch, en_decode, en_compute, en_mem, en_wb}, 5'b00010);
    repeat (3) step();
    checkOutput("wait_en_hold", {en_fetch, en_decode, en_compute, en_mem, en_wb}, 5'b00010);
    checkOutput("wait_vw", v_w, 1'b0);
    checkOutput("wait_stall", stall_cycles, 16'd4);
    quiet(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("release_en", {en_fetch, en_decode, en_compute, en_mem, en_wb}, 5'b11110);
    step();
    checkOutput("release_vw", v_w, 1'b1);

    // Jump together with a load-use hazard.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    checkOutput("jump_flush", flush, 1'b1);
    checkOutput("jump_en", {en_fetch, en_decode, en_compute, en_mem, en_wb}, 5'b10011);
    step();
    checkOutput("jump_valid_bits", {v_d, v_c, v_m, v_w}, 4'b0001);
    checkOutput("jump_stall", stall_cycles, 16'd4);
    checkOutput("flush_state_flush", flush, 1'b0);
    quiet(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_state_en", {en_fetch, en_decode, en_compute, en_mem, en_wb}, 5'b10000);
    step();
    checkOutput("after_flush_valid", {v_d, v_c, v_m, v_w}, 4'b1000);
    repeat (3) step();

    // Random traffic with small register indices so hazards occur often.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom % 64) == 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
                    ($urandom % 4) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                    ($urandom % 4) != 0, 1'($urandom));
      step();
    end

    // Saturate the counter with a long memory wait, then reset mid-wait.
    quiet(1'b1, 1'b1, 1'b1, 1'b0);
    step();
    quiet(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (4) step();
    quiet(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (65540) step();
    checkOutput("sat_stall", stall_cycles, 16'hFFFF);
    quiet(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("abort_valid", {v_d, v_c, v_m, v_w}, 4'b0000);
    checkOutput("abort_stall", stall_cycles, 16'd0);
    quiet(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("abort_en", {en_fetch, en_decode, en_compute, en_mem, en_wb}, 5'b10000);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1; one clock; reset is synchronous and active-high.
REQ-003 SHALL have port fetch_done, input, 1; fetch unit holds a valid instruction word this cycle.
REQ-004 SHALL have port mem_done, input, 1; memory-stage transaction completes this cycle.
REQ-005 SHALL have ports d_rs1, d_rs2, input, 5 each; source register indices of the instruction in decode.
REQ-006 SHALL have ports d_uses_rs1, d_uses_rs2, input, 1 each; decode instruction reads that source.
REQ-007 SHALL have ports c_rd (input, 5), c_writes_rd (input, 1), c_is_load (input, 1); describe the instruction in compute.
REQ-008 SHALL have port jump_valid, input, 1; registered jump-target enable from compute, meaningful only while v_m=1.
REQ-009 SHALL have ports en_fetch, en_decode, en_compute, en_mem, en_wb, output, 1 each; per-stage enables.
REQ-010 SHALL have port flush, output, 1; fetch redirect to jump target this cycle.
REQ-011 SHALL have ports v_d, v_c, v_m, v_w, output, 1 each; stage-valid bits.
REQ-012 SHALL have port stall_cycles, output, 16; saturating stall counter.

Function
REQ-013 SHALL implement a state machine with states RUN, MEM_WAIT, FLUSH.
REQ-014 mem_busy SHALL be v_m & ~mem_done (combinational).
REQ-015 hazard SHALL be v_d & v_c & c_is_load & c_writes_rd & (c_rd != 0) & ((d_uses_rs1 & d_rs1==c_rd) | (d_uses_rs2 & d_rs2==c_rd)).
REQ-016 Priority per cycle SHALL be: reset > jump (v_m & jump_valid & ~mem_busy) > mem_busy > hazard > normal advance.
REQ-017 Normal advance (RUN): v_w<=v_m, v_m<=v_c, v_c<=v_d, v_d<=fetch_done; en_fetch=1; en_decode=v_d; en_compute=v_c; en_mem=v_m; en_wb=v_w.
REQ-018 mem_busy in RUN SHALL: go to MEM_WAIT; hold all valid bits, except v_w<=0; drive all enables 0 except en_mem=1.
REQ-019 MEM_WAIT SHALL hold all valid bits with en_mem=1 and other enables 0 until mem_done=1; that cycle performs the normal advance of REQ-017 and returns to RUN (or FLUSH if jump_valid).
REQ-020 hazard in RUN SHALL: hold v_d; bubble compute (v_c<=0); advance v_m<=v_c and v_w<=v_m; en_fetch=0, en_decode=0, en_compute=1, en_mem=v_m, en_wb=v_w; stay in RUN. One bubble per load-use pair.
REQ-021 jump SHALL: drive flush=1 for exactly that cycle; set v_d<=0, v_c<=0; v_w<=v_m, v_m<=0; en_fetch=1, en_mem=1, en_wb=v_w, en_decode=en_compute=0; go to FLUSH.
REQ-022 FLUSH SHALL last exactly one cycle: v_d<=fetch_done, v_w<=0, others unchanged; en_fetch=1, other enables 0, flush=0; then RUN.
REQ-023 A hazard coincident with jump or mem_busy SHALL be ignored for that cycle.
REQ-024 stall_cycles SHALL increment by 1 on every cycle in MEM_WAIT, every mem_busy cycle in RUN, and every hazard cycle; it saturates at 16'hFFFF and never wraps.
REQ-025 Register index 0 SHALL never produce a hazard.
REQ-026 All outputs except flush and the enables SHALL be registered; the enables and flush are combinational from state, valid bits and inputs.

Reset
REQ-027 With reset=1 at a rising edge: state<=RUN, v_d=v_c=v_m=v_w=0, stall_cycles<=0; flush=0 and all enables 0 while reset=1.
REQ-028 Reset during MEM_WAIT or FLUSH SHALL abort the operation and return to RUN with all valid bits cleared; no partial advance.
REQ-029 First cycle after reset: en_fetch=1, other enables 0.

Verification
REQ-030 Fill: reset, then fetch_done=1 constantly with no hazards -> v_d,v_c,v_m,v_w become 1 on cycles 1,2,3,4; all enables 1 from cycle 4; stall_cycles=0.
REQ-031 Load-use: c_is_load=1, c_rd=5, c_writes_rd=1, d_rs1=5, d_uses_rs1=1, all valid -> one cycle with en_fetch=en_decode=0 and v_c=0 next; stall_cycles=1; c_rd=0 with same stimulus -> no stall.
REQ-032 Memory wait: v_m=1, mem_done=0 for 3 cycles then 1 -> MEM_WAIT for 3 cycles with en_mem=1 and others 0; v_w=0 during wait; stall_cycles=3; advance on the 4th cycle.
REQ-033 Jump: jump_valid=1 with v_m=1, mem_done=1 -> flush=1 for one cycle; v_d=v_c=v_m=0 next; FLUSH for one cycle; RUN after.
REQ-034 Jump concurrent with hazard -> flush wins; no stall counted; stall_cycles unchanged.
REQ-035 Saturation: preload via 65540 stall cycles -> stall_cycles=16'hFFFF; reset mid-MEM_WAIT -> all valid 0, stall_cycles=0, state RUN.
